// File: rtl/seven_seg_frame_decoder.sv
// Monitors the active-low segment patterns driven to a multi-digit display, decodes them back
// to digit codes plus decimal points, and publishes a frame only once it has held steady.
module seven_seg_frame_decoder #(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_FRAMES = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    seg_valid,
    input  logic [2:0]              seg_idx,
    input  logic [7:0]              seg_bits,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic                    frame_valid,
    output logic                    frame_err
);

    localparam logic [3:0]            STABLE_MAX = 4'(STABLE_FRAMES);
    localparam logic [NUM_DIGITS-1:0] MASK_FULL  = '1;

    function automatic logic [3:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h40:   decode_seg = 4'h0;
            7'h79:   decode_seg = 4'h1;
            7'h24:   decode_seg = 4'h2;
            7'h30:   decode_seg = 4'h3;
            7'h19:   decode_seg = 4'h4;
            7'h12:   decode_seg = 4'h5;
            7'h02:   decode_seg = 4'h6;
            7'h78:   decode_seg = 4'h7;
            7'h00:   decode_seg = 4'h8;
            7'h10:   decode_seg = 4'h9;
            7'h7F:   decode_seg = 4'hF;
            default: decode_seg = 4'hE;
        endcase
    endfunction

    logic [4*NUM_DIGITS-1:0] shadow_code_q, shadow_code_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q,   shadow_dp_d;
    logic [NUM_DIGITS-1:0]   mask_q,        mask_d;
    logic [4*NUM_DIGITS-1:0] prev_code_q,   prev_code_d;
    logic [NUM_DIGITS-1:0]   prev_dp_q,     prev_dp_d;
    logic [3:0]              stable_cnt_q,  stable_cnt_d;
    logic [4*NUM_DIGITS-1:0] digits_q,      digits_d;
    logic [NUM_DIGITS-1:0]   dp_q,          dp_d;
    logic                    valid_q,       valid_d;
    logic                    err_q,         err_d;

    logic       wr_en;
    logic [3:0] wr_code;
    logic       wr_dp;
    logic       compare;
    logic       same;
    logic       publish;
    logic       any_invalid;

    assign wr_code = decode_seg(seg_bits[6:0]);
    assign wr_dp   = ~seg_bits[7];
    assign wr_en   = seg_valid && ({1'b0, seg_idx} < 4'(NUM_DIGITS));
    assign compare = (mask_q == MASK_FULL);
    assign same    = (shadow_code_q == prev_code_q) && (shadow_dp_q == prev_dp_q);

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        shadow_code_d = shadow_code_q;
        shadow_dp_d   = shadow_dp_q;
        mask_d        = mask_q;
        prev_code_d   = prev_code_q;
        prev_dp_d     = prev_dp_q;
        stable_cnt_d  = stable_cnt_q;
        digits_d      = digits_q;
        dp_d          = dp_q;
        err_d         = err_q;
        valid_d       = 1'b0;
        publish       = 1'b0;
        any_invalid   = 1'b0;

        // The cycle after a frame completes: compare against the previous frame and reopen the mask.
        if (compare) begin
            mask_d = '0;
            if (same) begin
                stable_cnt_d = (stable_cnt_q >= STABLE_MAX) ? STABLE_MAX : stable_cnt_q + 4'd1;
            end else begin
                stable_cnt_d = 4'd1;
                prev_code_d  = shadow_code_q;
                prev_dp_d    = shadow_dp_q;
            end
            publish = (stable_cnt_d == STABLE_MAX) && ((stable_cnt_q != STABLE_MAX) || !same);
        end

        // A write landing in the compare cycle belongs to the next frame, so it is applied after the clear.
        if (wr_en) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (seg_idx == 3'(i)) begin
                    shadow_code_d[4*i +: 4] = wr_code;
                    shadow_dp_d[i]          = wr_dp;
                    mask_d[i]               = 1'b1;
                end
            end
        end

        if (publish) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (prev_code_d[4*i +: 4] == 4'hE) begin
                    any_invalid = 1'b1;
                end
            end
            digits_d = prev_code_d;
            dp_d     = prev_dp_d;
            err_d    = any_invalid;
            valid_d  = 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments; the shadow and prev storage is reset too, because a partial frame must not survive a reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow_code_q <= '0;
            shadow_dp_q   <= '0;
            mask_q        <= '0;
            prev_code_q   <= '0;
            prev_dp_q     <= '0;
            stable_cnt_q  <= '0;
            digits_q      <= '1;
            dp_q          <= '0;
            valid_q       <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            shadow_code_q <= shadow_code_d;
            shadow_dp_q   <= shadow_dp_d;
            mask_q        <= mask_d;
            prev_code_q   <= prev_code_d;
            prev_dp_q     <= prev_dp_d;
            stable_cnt_q  <= stable_cnt_d;
            digits_q      <= digits_d;
            dp_q          <= dp_d;
            valid_q       <= valid_d;
            err_q         <= err_d;
        end
    end

    assign digits_out  = digits_q;
    assign dp_out      = dp_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;

endmodule

// File: tb/tb_seven_seg_frame_decoder.sv
// Self-checking bench for seven_seg_frame_decoder: expected publishes are queued as frames are
// driven and compared, including their arrival cycle, whenever frame_valid pulses.
module tb_seven_seg_frame_decoder;

    localparam int ND = 6;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            seg_valid = 1'b0;
    logic [2:0]      seg_idx = '0;
    logic [7:0]      seg_bits = '0;
    logic [4*ND-1:0] digits_out;
    logic [ND-1:0]   dp_out;
    logic            frame_valid;
    logic            frame_err;

    seven_seg_frame_decoder #(.NUM_DIGITS(ND), .STABLE_FRAMES(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .seg_valid  (seg_valid),
        .seg_idx    (seg_idx),
        .seg_bits   (seg_bits),
        .digits_out (digits_out),
        .dp_out     (dp_out),
        .frame_valid(frame_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4*ND-1:0] digits;
        logic [ND-1:0]   dp;
        logic            err;
        int              cyc;
    } exp_t;

    typedef struct {
        logic [7:0] bits;
        logic [3:0] code;
        logic       dp;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every frame_valid pulse must match the oldest queued expectation, on the predicted cycle.
    always @(negedge clk) begin
        if (frame_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("pub_cycle", cyc, mon_e.cyc);
                check("pub_digits", 32'(digits_out), 32'(mon_e.digits));
                check("pub_dp", 32'(dp_out), 32'(mon_e.dp));
                check("pub_err", 32'(frame_err), 32'(mon_e.err));
            end
        end
    end

    task automatic wr(input logic [2:0] idx, input logic [7:0] bits);
        seg_valid = 1'b1;
        seg_idx   = idx;
        seg_bits  = bits;
        @(posedge clk);
        #1;
        seg_valid = 1'b0;
    endtask

    task automatic expect_pub(input logic [4*ND-1:0] d, input logic [ND-1:0] p, input logic e);
        exp_t x;
        x.digits = d;
        x.dp     = p;
        x.err    = e;
        x.cyc    = cyc + 2;
        sb.push_back(x);
    endtask

    // Frames are written back to back, so each frame's first write lands in the previous compare cycle.
    task automatic send_frame(input logic [8*ND-1:0] pats, input bit pub,
                              input logic [4*ND-1:0] d, input logic [ND-1:0] p, input logic e);
        for (int i = 0; i < ND; i++) begin
            if (i == ND - 1 && pub) expect_pub(d, p, e);
            wr(3'(i), pats[8*i +: 8]);
        end
    endtask

    task automatic settle(input string name);
        for (int i = 0; i < 10; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        repeat (4) @(posedge clk);
        #1;
        check(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_digits"}, 32'(digits_out), 32'hFFFFFF);
        check({name, "_dp"}, 32'(dp_out), 32'd0);
        check({name, "_valid"}, 32'(frame_valid), 32'd0);
        check({name, "_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    localparam logic [8*ND-1:0] PAT_A   = 48'h82_92_99_B0_A4_F9;
    localparam logic [8*ND-1:0] PAT_B   = 48'h82_92_99_B0_A4_C0;
    localparam logic [8*ND-1:0] PAT_INV = 48'hC0_C0_C0_40_FF_88;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{8'hC0, 4'h0, 1'b0};
        vecs[1]  = '{8'hF9, 4'h1, 1'b0};
        vecs[2]  = '{8'hA4, 4'h2, 1'b0};
        vecs[3]  = '{8'hB0, 4'h3, 1'b0};
        vecs[4]  = '{8'h99, 4'h4, 1'b0};
        vecs[5]  = '{8'h92, 4'h5, 1'b0};
        vecs[6]  = '{8'h82, 4'h6, 1'b0};
        vecs[7]  = '{8'hF8, 4'h7, 1'b0};
        vecs[8]  = '{8'h80, 4'h8, 1'b0};
        vecs[9]  = '{8'h90, 4'h9, 1'b0};
        vecs[10] = '{8'h7F, 4'hF, 1'b1};
        vecs[11] = '{8'h79, 4'h1, 1'b1};
        vecs[12] = '{8'h08, 4'hE, 1'b1};
        vecs[13] = '{8'hFF, 4'hF, 1'b0};
        vecs[14] = '{8'h3C, 4'hE, 1'b1};

        // Reset held for two cycles.
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Three identical frames publish once; a fourth is silent and outputs hold.
        send_frame(PAT_A, 1'b0, '0, '0, 1'b0);
        send_frame(PAT_A, 1'b0, '0, '0, 1'b0);
        send_frame(PAT_A, 1'b1, 24'h654321, 6'b0, 1'b0);
        settle("stable_drain");
        send_frame(PAT_A, 1'b0, '0, '0, 1'b0);
        settle("saturated_drain");
        check("saturated_hold", 32'(digits_out), 32'h654321);

        // A,A,B,B,B: only the third B publishes; outputs hold while B is counting.
        send_frame(PAT_A, 1'b0, '0, '0, 1'b0);
        send_frame(PAT_A, 1'b0, '0, '0, 1'b0);
        send_frame(PAT_B, 1'b0, '0, '0, 1'b0);
        send_frame(PAT_B, 1'b0, '0, '0, 1'b0);
        settle("unstable_drain");
        check("unstable_hold", 32'(digits_out), 32'h654321);
        send_frame(PAT_B, 1'b1, 24'h654320, 6'b0, 1'b0);
        settle("restart_drain");

        // Invalid, blank and decimal-point decode.
        send_frame(PAT_INV, 1'b0, '0, '0, 1'b0);
        send_frame(PAT_INV, 1'b0, '0, '0, 1'b0);
        send_frame(PAT_INV, 1'b1, 24'h0000FE, 6'b000100, 1'b1);
        settle("invalid_drain");

        // Out-of-range indices are ignored; a rewritten position keeps its last value.
        for (int f = 0; f < 3; f++) begin
            wr(3'd0, 8'hF9);
            wr(3'd1, 8'hA4);
            wr(3'd6, 8'h88);
            wr(3'd2, 8'hF9);
            wr(3'd7, 8'h00);
            wr(3'd2, 8'hA4);
            wr(3'd3, 8'h99);
            wr(3'd4, 8'h92);
            if (f == 2) expect_pub(24'h654221, 6'b0, 1'b0);
            wr(3'd5, 8'h82);
        end
        settle("overwrite_drain");

        // Reset mid-operation discards both the count and the partial frame.
        send_frame(PAT_A, 1'b0, '0, '0, 1'b0);
        send_frame(PAT_A, 1'b0, '0, '0, 1'b0);
        wr(3'd0, 8'hF9);
        wr(3'd1, 8'hA4);
        wr(3'd2, 8'hB0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_reset_outputs("midreset");
        send_frame(PAT_A, 1'b0, '0, '0, 1'b0);
        send_frame(PAT_A, 1'b0, '0, '0, 1'b0);
        settle("postreset_drain");
        check("postreset_hold", 32'(digits_out), 32'hFFFFFF);
        send_frame(PAT_A, 1'b1, 24'h654321, 6'b0, 1'b0);
        settle("postreset_pub_drain");

        // Decode table: every digit position carries the same pattern for three frames.
        for (int k = 0; k < 15; k++) begin
            send_frame({ND{vecs[k].bits}}, 1'b0, '0, '0, 1'b0);
            send_frame({ND{vecs[k].bits}}, 1'b0, '0, '0, 1'b0);
            send_frame({ND{vecs[k].bits}}, 1'b1, {ND{vecs[k].code}}, {ND{vecs[k].dp}},
                       (vecs[k].code == 4'hE));
        end
        settle("table_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
